bus_memory_target: RTL and testbench

- Responder end of the system bus that the JTAG DMA initiator (jtag_support) drives.
- Decodes begin_transaction cycles against a fixed address window and serves single and burst reads and writes from an internal word-addressed RAM.
- Signals errors for illegal bursts and inserts configurable wait states via busyOUT.
- Sits on the system_clock side as a bus slave next to other targets; all outputs are zero when not selected, so the target is wired-OR safe.

---
 rtl/bus_target_pkg.sv | 21 ++
 rtl/bus_memory_target_if.sv | 36 +++
 rtl/bus_target_ram.sv | 36 +++
 rtl/bus_memory_target.sv | 179 +++++++++++++++++
 tb/tb_bus_memory_target.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_target_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_target_pkg
// Brief   : Shared state encoding and counter widths for the bus memory target.
// Revision: 1.0 - initial release
// ============================================================================
package bus_target_pkg;

    localparam int BEAT_CNT_W = 9;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        WDONE = 3'd3,
        ERROR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_memory_target_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_memory_target_if
// Brief   : System bus between the JTAG DMA initiator and a memory target.
// Revision: 1.0 - initial release
// ============================================================================
interface bus_memory_target_if;

    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        input  begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        output begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );

endinterface
`default_nettype wire

// File: rtl/bus_target_ram.sv
`default_nettype none
// ============================================================================
// Module  : bus_target_ram
// Brief   : Single-port word RAM, synchronous read, per-byte write enables.
// Revision: 1.0 - initial release
// ============================================================================
module bus_target_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  system_clock,
    input  wire logic [ADDR_WIDTH-1:0] i_addr,
    input  wire logic                  i_rd_en,
    input  wire logic [3:0]            i_wr_be,
    input  wire logic [31:0]           i_wr_data,
    output logic      [31:0]           o_rd_data
);

    logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [31:0] r_rd_data;

    // Read register holds its value when not enabled so stalled beats stay stable
    always_ff @(posedge system_clock) begin
        for (int b = 0; b < 4; b++) begin
            if (i_wr_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/bus_memory_target.sv
`default_nettype none
// ============================================================================
// Module  : bus_memory_target
// Brief   : Bus slave serving single/burst reads and writes from internal RAM.
// Revision: 1.0 - initial release
// ============================================================================
module bus_memory_target
    import bus_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5555_0000,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          WAIT_STATES  = 0,
    parameter int          READ_LATENCY = 1
) (
    input  wire logic            system_clock,
    input  wire logic            system_reset_n,
    bus_memory_target_if.slave   bus
);

    localparam int c_sum_w     = ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8) + 1;
    localparam int c_index_max = (2**ADDR_WIDTH) - 1;

    generate
        if (READ_LATENCY != 1) begin : g_bad_latency
            $error("bus_memory_target supports READ_LATENCY = 1 only");
        end
    endgenerate

    state_t                  r_state,   w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr,     w_ptr_nxt;
    logic [BEAT_CNT_W-1:0]   r_beats,   w_beats_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait,    w_wait_nxt;
    logic [3:0]              r_be,      w_be_nxt;
    logic                    r_end_out, w_end_out_nxt;

    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic                    w_ram_rd_en;
    logic [3:0]              w_ram_wr_be;
    logic [31:0]             w_ram_rd_data;

    logic                    w_selected;
    logic [ADDR_WIDTH-1:0]   w_index;
    logic                    w_overrun;
    logic                    w_busy;
    logic                    w_write_beat;
    logic                    w_last;
    logic                    w_unused_ok;

    assign w_selected  = (bus.address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
    assign w_index     = bus.address_dataIN[ADDR_WIDTH+1:2];
    assign w_overrun   = (c_sum_w'(w_index) + c_sum_w'(bus.burst_sizeIN)) > c_sum_w'(c_index_max);
    assign w_busy      = (r_state == WRITE) && (r_wait != '0);
    assign w_last      = (r_beats == BEAT_CNT_W'(1));
    assign w_unused_ok = &{1'b0, bus.address_dataIN[1:0]};

    // Abort outranks a data beat presented in the same cycle
    assign w_write_beat = (r_state == WRITE) && !bus.end_transactionIN &&
                          bus.data_validIN && !w_busy;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_beats   <= '0;
            r_wait    <= '0;
            r_be      <= '0;
            r_end_out <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_beats   <= w_beats_nxt;
            r_wait    <= w_wait_nxt;
            r_be      <= w_be_nxt;
            r_end_out <= w_end_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_beats_nxt   = r_beats;
        w_wait_nxt    = r_wait;
        w_be_nxt      = r_be;
        w_end_out_nxt = 1'b0;
        w_ram_addr    = r_ptr;
        w_ram_rd_en   = 1'b0;
        w_ram_wr_be   = 4'b0000;

        case (r_state)
            IDLE: begin
                if (bus.begin_transactionIN && w_selected) begin
                    w_ram_addr  = w_index;
                    w_ptr_nxt   = w_index;
                    w_be_nxt    = bus.byte_enableIN;
                    w_beats_nxt = BEAT_CNT_W'({1'b0, bus.burst_sizeIN}) + BEAT_CNT_W'(1);
                    w_wait_nxt  = '0;
                    if (w_overrun) begin
                        w_state_nxt = ERROR;
                    end else if (bus.read_n_writeIN) begin
                        w_ram_rd_en = 1'b1;
                        w_state_nxt = READ;
                    end else begin
                        w_state_nxt = WRITE;
                    end
                end
            end

            READ: begin
                if (bus.end_transactionIN) begin
                    w_state_nxt = IDLE;
                end else if (!bus.busyIN) begin
                    if (w_last) begin
                        w_state_nxt   = IDLE;
                        w_end_out_nxt = 1'b1;
                    end else begin
                        // Prefetch the next word so it appears on the following cycle
                        w_ram_addr  = r_ptr + ADDR_WIDTH'(1);
                        w_ram_rd_en = 1'b1;
                        w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
                        w_beats_nxt = r_beats - BEAT_CNT_W'(1);
                    end
                end
            end

            WRITE: begin
                if (bus.end_transactionIN) begin
                    w_state_nxt = IDLE;
                end else begin
                    if (r_wait != '0) begin
                        w_wait_nxt = r_wait - WAIT_CNT_W'(1);
                    end
                    if (w_write_beat) begin
                        w_ram_wr_be = r_be;
                        w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
                        w_beats_nxt = r_beats - BEAT_CNT_W'(1);
                        w_wait_nxt  = WAIT_CNT_W'(WAIT_STATES);
                        if (w_last) begin
                            w_state_nxt = WDONE;
                        end
                    end
                end
            end

            WDONE: begin
                if (bus.end_transactionIN) begin
                    w_state_nxt = IDLE;
                end
            end

            ERROR: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    bus_target_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .system_clock (system_clock),
        .i_addr       (w_ram_addr),
        .i_rd_en      (w_ram_rd_en),
        .i_wr_be      (w_ram_wr_be),
        .i_wr_data    (bus.address_dataIN),
        .o_rd_data    (w_ram_rd_data)
    );

    // Outputs derive from state so they are zero whenever the target is not engaged
    assign bus.address_dataOUT    = (r_state == READ) ? w_ram_rd_data : 32'h0;
    assign bus.data_validOUT      = (r_state == READ);
    assign bus.end_transactionOUT = r_end_out;
    assign bus.busyOUT            = w_busy;
    assign bus.errorOUT           = (r_state == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_bus_memory_target.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_memory_target
// Brief   : Randomised scoreboard bench for bus_memory_target.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_memory_target;

    localparam logic [31:0] c_base  = 32'h5555_0000;
    localparam int          c_aw    = 10;
    localparam int          c_ws    = 2;
    localparam int          c_depth = 1024;
    localparam int          K_DATA  = 0;
    localparam int          K_END   = 1;
    localparam int          K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } exp_t;

    logic system_clock   = 1'b0;
    logic system_reset_n = 1'b0;
    always #5 system_clock = ~system_clock;

    bus_memory_target_if bus ();

    bus_memory_target #(
        .BASE_ADDRESS (c_base),
        .ADDR_WIDTH   (c_aw),
        .WAIT_STATES  (c_ws),
        .READ_LATENCY (1)
    ) dut (
        .system_clock   (system_clock),
        .system_reset_n (system_reset_n),
        .bus            (bus)
    );

    exp_t        exp_q [$];
    logic [31:0] wq [$];
    logic [31:0] model_mem [0:c_depth-1];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic bit is_sel(logic [31:0] a);
        return (a >> (c_aw + 2)) == (c_base >> (c_aw + 2));
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a >> 2) % c_depth);
    endfunction

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.address_dataIN      = '0;
        bus.byte_enableIN       = '0;
        bus.burst_sizeIN        = '0;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.busyIN              = 1'b0;
    endtask

    task automatic check_quiet(string name);
        check({name, "_flags"}, {28'h0, bus.data_validOUT, bus.end_transactionOUT,
                                 bus.busyOUT, bus.errorOUT}, 32'h0);
        check({name, "_data"}, bus.address_dataOUT, 32'h0);
    endtask

    // Issues the begin cycle; returns 1 if a data phase follows
    task automatic start(input logic [31:0] addr, input int bsize, input logic [3:0] be,
                         input logic rnw, output bit go);
        go = 1'b0;
        bus.address_dataIN      = addr;
        bus.byte_enableIN       = be;
        bus.burst_sizeIN        = 8'(bsize);
        bus.read_n_writeIN      = rnw;
        bus.begin_transactionIN = 1'b1;
        if (is_sel(addr) && (idx_of(addr) + bsize > c_depth - 1)) begin
            exp_q.push_back('{kind: K_ERR, data: 32'h0});
        end
        tick();
        bus.begin_transactionIN = 1'b0;
        if (!is_sel(addr)) begin
            check_quiet("unselected");
            tick();
            check_quiet("unselected_later");
        end else if (idx_of(addr) + bsize > c_depth - 1) begin
            tick();
            tick();
            check_quiet("after_error");
        end else begin
            go = 1'b1;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input int bsize, input logic [3:0] be,
                            input int abort_at);
        bit          go;
        bit          pend = 1'b0;
        int          idx = idx_of(addr);
        int          k = 0;
        int          run = 0;
        int          cyc = 0;
        logic [31:0] d;
        start(addr, bsize, be, 1'b0, go);
        if (!go) begin
            wq.delete();
            return;
        end
        while (k <= bsize) begin
            if (abort_at == k) begin
                bus.end_transactionIN = 1'b1;
                bus.data_validIN      = 1'b1;
                bus.address_dataIN    = $urandom;
                tick();
                bus.end_transactionIN = 1'b0;
                bus.data_validIN      = 1'b0;
                tick();
                check_quiet("after_write_abort");
                wq.delete();
                return;
            end
            if (bus.busyOUT) begin
                run++;
            end else if (pend) begin
                check("wait_state_len", 32'(run), 32'(c_ws));
                pend = 1'b0;
            end
            if (bus.busyOUT) begin
                // junk presented while stalled must never reach the RAM
                bus.data_validIN   = 1'b1;
                bus.address_dataIN = $urandom;
            end else if ($urandom_range(0, 3) != 0) begin
                d = (wq.size() != 0) ? wq.pop_front() : $urandom;
                bus.data_validIN   = 1'b1;
                bus.address_dataIN = d;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[idx + k][8*b +: 8] = d[8*b +: 8];
                end
                k++;
                if (k <= bsize) begin
                    pend = 1'b1;
                    run  = 0;
                end
            end else begin
                bus.data_validIN   = 1'b0;
                bus.address_dataIN = $urandom;
            end
            tick();
            cyc++;
            if (cyc > 3000) begin
                check("write_timeout", 32'(k), 32'(bsize + 1));
                break;
            end
        end
        bus.data_validIN = 1'b0;
        check("busy_in_wdone", {31'h0, bus.busyOUT}, 32'h0);
        repeat ($urandom_range(0, 2)) tick();
        bus.end_transactionIN = 1'b1;
        tick();
        bus.end_transactionIN = 1'b0;
        check_quiet("after_write");
        wq.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input int bsize, input int stall_pct,
                           input int stall_beat, input int abort_at, input int reset_at);
        bit go;
        int idx = idx_of(addr);
        int n;
        int k = 0;
        int sd = 0;
        int cyc = 0;
        n = (abort_at >= 0) ? abort_at : ((reset_at >= 0) ? reset_at : bsize + 1);
        if (is_sel(addr) && (idx + bsize <= c_depth - 1)) begin
            for (int i = 0; i < n; i++) exp_q.push_back('{kind: K_DATA, data: model_mem[idx + i]});
            if (abort_at < 0 && reset_at < 0) exp_q.push_back('{kind: K_END, data: 32'h0});
        end
        start(addr, bsize, 4'h0, 1'b1, go);
        if (!go) return;
        while (k <= bsize) begin
            if (abort_at == k) begin
                bus.end_transactionIN = 1'b1;
                bus.busyIN            = 1'b1;
                tick();
                bus.end_transactionIN = 1'b0;
                bus.busyIN            = 1'b0;
                check_quiet("after_read_abort");
                tick();
                return;
            end
            if (reset_at == k) begin
                #2;
                system_reset_n = 1'b0;
                #1;
                check_quiet("async_reset");
                tick();
                system_reset_n = 1'b1;
                tick();
                check_quiet("after_reset");
                return;
            end
            if (k == stall_beat && sd < 2) begin
                bus.busyIN = 1'b1;
                sd++;
            end else begin
                bus.busyIN = ($urandom_range(0, 99) < stall_pct);
            end
            if (bus.data_validOUT && !bus.busyIN) k++;
            tick();
            cyc++;
            if (cyc > 3000) begin
                check("read_timeout", 32'(k), 32'(bsize + 1));
                break;
            end
        end
        bus.busyIN = 1'b0;
        tick();
        tick();
        check_quiet("after_read");
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents a response
    always @(negedge system_clock) begin : mon
        exp_t e;
        if (system_reset_n) begin
            if (bus.data_validOUT && !bus.busyIN) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_DATA) begin
                    e = exp_q.pop_front();
                    check("read_data", bus.address_dataOUT, e.data);
                end else begin
                    check("unexpected_read_beat", {31'h0, bus.data_validOUT}, 32'h0);
                end
            end else if (bus.data_validOUT) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_DATA)
                    check("stall_hold_data", bus.address_dataOUT, exp_q[0].data);
            end else begin
                check("rdata_zero_when_invalid", bus.address_dataOUT, 32'h0);
            end
            if (bus.end_transactionOUT) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_END) begin
                    e = exp_q.pop_front();
                    check("end_strobe_no_valid", {31'h0, bus.data_validOUT}, 32'h0);
                end else begin
                    check("unexpected_end_strobe", {31'h0, bus.end_transactionOUT}, 32'h0);
                end
            end
            if (bus.errorOUT) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_ERR) begin
                    e = exp_q.pop_front();
                    check("error_no_busy", {31'h0, bus.busyOUT}, 32'h0);
                end else begin
                    check("unexpected_error", {31'h0, bus.errorOUT}, 32'h0);
                end
            end
        end
    end

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin : main
        int          bs;
        int          ab;
        logic [31:0] a;
        idle_bus();
        repeat (3) tick();
        check_quiet("reset_state");
        system_reset_n = 1'b1;
        tick();

        for (int b = 0; b < 4; b++) do_write(c_base + 32'(b * 1024), 255, 4'hF, -1);

        wq.push_back(32'hAAAA_AAAA); wq.push_back(32'hBBBB_BBBB);
        wq.push_back(32'hCCCC_CCCC); wq.push_back(32'hDDDD_DDDD);
        do_write(32'h5555_0010, 3, 4'hF, -1);
        do_read(32'h5555_0010, 3, 0, 2, -1, -1);

        wq.push_back(32'hFFFF_FFFF);
        do_write(32'h5555_0000, 0, 4'hF, -1);
        wq.push_back(32'hDEAD_BEEF);
        do_write(32'h5555_0000, 0, 4'b0011, -1);
        do_read(32'h5555_0000, 0, 0, -1, -1, -1);

        do_write(32'hA000_0000, 2, 4'hF, -1);
        do_read(32'hA000_0000, 2, 0, -1, -1, -1);
        do_write(32'h5555_0FFC, 1, 4'hF, -1);
        do_read(32'h5555_0FFC, 1, 0, -1, -1, -1);
        do_read(32'h5555_0FF8, 1, 20, -1, -1, -1);

        do_write(32'h5555_0040, 5, 4'hF, 2);
        do_read(32'h5555_0040, 5, 0, -1, -1, -1);
        do_read(32'h5555_0040, 5, 0, -1, 1, -1);

        do_read(32'h5555_0010, 7, 30, -1, -1, 3);
        do_read(32'h5555_0010, 3, 0, -1, -1, -1);

        repeat (60) begin
            bs = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 15);
            a  = c_base + 32'($urandom_range(0, c_depth - 1) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            ab = ($urandom_range(0, 6) == 0) ? $urandom_range(0, bs) : -1;
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, bs, 4'($urandom_range(0, 15)), ab);
            end else begin
                do_read(a, bs, 25, -1, ab, -1);
            end
        end

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
